// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory
// address, buffers {pc, instr} pairs in a small FIFO and hands them to decode
// over a valid/ready handshake. Redirects flush the buffer and reload the PC.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0004,
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_1000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        oob_stall,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int              PTR_W     = $clog2(DEPTH);
  localparam logic [PTR_W:0]  DEPTH_CNT = (PTR_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   rd_ptr;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W:0]     count;
  logic [31:0]        pc_q;
  logic               push;
  logic               pop;
  entry_t             head;

  // The memory address is the PC register itself, so no input reaches it
  // combinationally.
  assign imem_addr = pc_q;
  assign oob_stall = (pc_q >= ADDR_LIMIT);
  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;
  // A full buffer may still accept an entry when the head leaves this cycle.
  assign push      = !redirect_valid && !oob_stall && ((count < DEPTH_CNT) || pop);

  // Head entry toward decode; forced to zero while the buffer is empty so the
  // outputs read clean after reset and flushes.
  always_comb begin
    head      = fifo_q[rd_ptr];
    out_pc    = '0;
    out_instr = '0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_instr = head.instr;
    end
  end

  // Fetch-buffer storage.
  // NOTE: the data array has no reset; validity is tracked by count alone,
  // which keeps the storage a plain register file.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: pc_q, instr: imem_instr};
  end

  // PC, pointers, occupancy and the sticky misalignment flag.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side here sees the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      misalign_err <= 1'b0;
    end else if (redirect_valid) begin
      // Flush everything; a pop in this cycle is still counted below.
      pc_q   <= {redirect_pc[31:2], 2'b00};
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
    end else begin
      if (push) begin
        pc_q   <= pc_q + 32'd4;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Completed handshakes, including one that coincides with a redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fetch_count <= '0;
    else if (pop) fetch_count <= fetch_count + 32'd1;
  end

endmodule
